peatc_tx_arbiter: RTL and testbench



---
 rtl/peatc_pkg.sv | 22 ++
 rtl/peatc_rr_pick.sv | 19 +
 rtl/peatc_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_peatc_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/peatc_pkg.sv
// rtl/peatc_pkg.sv - shared state encoding, source IDs and framing constants for the TX arbiter
package peatc_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_TRAILER = 2'd3;

  localparam logic [7:0] SRC_GS = 8'h01;
  localparam logic [7:0] SRC_RN = 8'h02;

  localparam logic [7:0] SYNC_HDR_DEF = 8'hA5;
  localparam logic [7:0] SYNC_TRL_DEF = 8'h5A;

  // OR-ed into the trailer source ID when a packet was cut at MAX_PKT
  localparam logic [7:0] TRUNC_FLAG = 8'h80;

  function automatic logic [15:0] swap16(input logic [15:0] s);
    return {s[7:0], s[15:8]};
  endfunction

endpackage

// File: rtl/peatc_rr_pick.sv
// rtl/peatc_rr_pick.sv - 2-way round-robin selector, one-hot grant
module peatc_rr_pick (
  input  logic [1:0] req,
  input  logic       last_rn,
  output logic [1:0] grant
);

  // On contention the requester that was not served last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_rn ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/peatc_tx_arbiter.sv
// rtl/peatc_tx_arbiter.sv - packet round-robin arbiter framing GS/RN samples into the host TX FIFO
module peatc_tx_arbiter
  import peatc_pkg::*;
#(
  parameter int         MAX_PKT    = 256,
  parameter bit         SWAP_BYTES = 1'b1,
  parameter logic [7:0] SYNC_HDR   = SYNC_HDR_DEF,
  parameter logic [7:0] SYNC_TRL   = SYNC_TRL_DEF
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iGS_Valid,
  input  logic [15:0] i16GS_Data,
  input  logic        iGS_Last,
  output logic        oGS_Ready,
  input  logic        iRN_Valid,
  input  logic [15:0] i16RN_Data,
  input  logic        iRN_Last,
  output logic        oRN_Ready,
  output logic        oTx_WriteEna,
  output logic [31:0] o32Tx_Data,
  input  logic        iTx_Full,
  output logic [1:0]  oGrant,
  output logic        oBusy,
  output logic [15:0] o16PktSeq,
  output logic        oOverLen
);

  localparam int CW = $clog2(MAX_PKT) + 1;

  logic [1:0]    state;
  logic [1:0]    grant;
  logic [7:0]    src_id;
  logic          last_rn;
  logic [CW-1:0] cnt;
  logic          trunc;
  logic [15:0]   seq;
  logic          over_len;

  logic [1:0]    pick;
  logic          sel_valid;
  logic          sel_last;
  logic [15:0]   sel_data;
  logic [15:0]   data_word;
  logic [CW-1:0] cnt_nxt;
  logic          at_max;
  logic          wr;
  logic          gs_rdy;
  logic          rn_rdy;
  logic [31:0]   tx_data;

  peatc_rr_pick u_pick (
    .req     ({iRN_Valid, iGS_Valid}),
    .last_rn (last_rn),
    .grant   (pick)
  );

  always_comb begin
    sel_valid = grant[1] ? iRN_Valid  : iGS_Valid;
    sel_last  = grant[1] ? iRN_Last   : iGS_Last;
    sel_data  = grant[1] ? i16RN_Data : i16GS_Data;
    data_word = SWAP_BYTES ? swap16(sel_data) : sel_data;
    cnt_nxt   = cnt + 1'b1;
    at_max    = (cnt_nxt == CW'(MAX_PKT));
  end

  // Handshakes are gated by reset so an abort takes effect in the same cycle
  always_comb begin
    wr      = 1'b0;
    gs_rdy  = 1'b0;
    rn_rdy  = 1'b0;
    tx_data = 32'h0;
    case (state)
      ST_HEADER: begin
        tx_data = {SYNC_HDR, src_id, seq};
        wr      = !iTx_Full;
      end
      ST_DATA: begin
        gs_rdy  = grant[0] & !iTx_Full;
        rn_rdy  = grant[1] & !iTx_Full;
        wr      = sel_valid & !iTx_Full;
        tx_data = {src_id, 8'h00, data_word};
      end
      ST_TRAILER: begin
        tx_data = {SYNC_TRL, src_id | (trunc ? TRUNC_FLAG : 8'h00), 16'(cnt)};
        wr      = !iTx_Full;
      end
      default: begin
        wr      = 1'b0;
        tx_data = 32'h0;
      end
    endcase
    wr     = wr & iReset;
    gs_rdy = gs_rdy & iReset;
    rn_rdy = rn_rdy & iReset;
  end

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      state    <= ST_IDLE;
      grant    <= 2'b00;
      src_id   <= 8'h00;
      last_rn  <= 1'b1;
      cnt      <= '0;
      trunc    <= 1'b0;
      seq      <= 16'h0000;
      over_len <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iEnable && (pick != 2'b00)) begin
            grant  <= pick;
            src_id <= pick[1] ? SRC_RN : SRC_GS;
            state  <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (wr) begin
            cnt   <= '0;
            trunc <= 1'b0;
            seq   <= seq + 16'h0001;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr) begin
            cnt <= cnt_nxt;
            // A Last that lands exactly on MAX_PKT is a normal end, not a truncation
            if (sel_last || at_max) begin
              trunc <= at_max & !sel_last;
              state <= ST_TRAILER;
            end
          end
        end
        ST_TRAILER: begin
          if (wr) begin
            last_rn  <= grant[1];
            over_len <= over_len | trunc;
            grant    <= 2'b00;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oGS_Ready    = gs_rdy;
  assign oRN_Ready    = rn_rdy;
  assign oTx_WriteEna = wr;
  assign o32Tx_Data   = tx_data;
  assign oGrant       = grant;
  assign oBusy        = (state != ST_IDLE);
  assign o16PktSeq    = seq;
  assign oOverLen     = over_len;

endmodule

// File: tb/tb_peatc_tx_arbiter.sv
// tb/tb_peatc_tx_arbiter.sv - scoreboard bench for peatc_tx_arbiter
module tb_peatc_tx_arbiter;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic        iGS_Valid;
  logic [15:0] i16GS_Data;
  logic        iGS_Last;
  logic        oGS_Ready;
  logic        iRN_Valid;
  logic [15:0] i16RN_Data;
  logic        iRN_Last;
  logic        oRN_Ready;
  logic        oTx_WriteEna;
  logic [31:0] o32Tx_Data;
  logic        iTx_Full;
  logic [1:0]  oGrant;
  logic        oBusy;
  logic [15:0] o16PktSeq;
  logic        oOverLen;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [16:0] gs_q[$];
  logic [16:0] rn_q[$];

  always #5 iClk = ~iClk;

  peatc_tx_arbiter #(.MAX_PKT(4), .SWAP_BYTES(1'b1), .SYNC_HDR(8'hA5), .SYNC_TRL(8'h5A)) dut (
    .iClk(iClk), .iReset(iReset), .iEnable(iEnable),
    .iGS_Valid(iGS_Valid), .i16GS_Data(i16GS_Data), .iGS_Last(iGS_Last), .oGS_Ready(oGS_Ready),
    .iRN_Valid(iRN_Valid), .i16RN_Data(i16RN_Data), .iRN_Last(iRN_Last), .oRN_Ready(oRN_Ready),
    .oTx_WriteEna(oTx_WriteEna), .o32Tx_Data(o32Tx_Data), .iTx_Full(iTx_Full),
    .oGrant(oGrant), .oBusy(oBusy), .o16PktSeq(o16PktSeq), .oOverLen(oOverLen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] src, input logic [15:0] s);
    return {8'hA5, src, s};
  endfunction
  function automatic logic [31:0] dat(input logic [7:0] src, input logic [15:0] s);
    return {src, 8'h00, s[7:0], s[15:8]};
  endfunction
  function automatic logic [31:0] trl(input logic [7:0] src, input bit t, input logic [15:0] c);
    return {8'h5A, src | (t ? 8'h80 : 8'h00), c};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  // Queue a packet of n samples on one source and its expected frame (n <= 4)
  task automatic gen(input bit rn, input int n, input logic [15:0] s0, input logic [15:0] seq);
    logic [7:0]  src;
    logic [15:0] s;
    src = rn ? 8'h02 : 8'h01;
    exp_q.push_back(hdr(src, seq));
    for (int i = 0; i < n; i++) begin
      s = s0 + 16'(i) * 16'h0101;
      if (rn) rn_q.push_back({(i == n - 1), s});
      else    gs_q.push_back({(i == n - 1), s});
      exp_q.push_back(dat(src, s));
    end
    exp_q.push_back(trl(src, 1'b0, 16'(n)));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || oBusy) && t < 400) begin
      cyc(1);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Source drivers: transfer decided by valid&ready sampled mid-cycle
  initial begin
    bit take;
    iGS_Valid = 1'b0; i16GS_Data = 16'h0; iGS_Last = 1'b0;
    forever begin
      @(negedge iClk);
      take = iGS_Valid && oGS_Ready;
      @(posedge iClk);
      #2;
      if (take && gs_q.size() > 0) gs_q.delete(0);
      if (gs_q.size() > 0) begin
        {iGS_Last, i16GS_Data} = gs_q[0];
        iGS_Valid = 1'b1;
      end else begin
        iGS_Valid = 1'b0;
        iGS_Last  = 1'b0;
      end
    end
  end

  initial begin
    bit take;
    iRN_Valid = 1'b0; i16RN_Data = 16'h0; iRN_Last = 1'b0;
    forever begin
      @(negedge iClk);
      take = iRN_Valid && oRN_Ready;
      @(posedge iClk);
      #2;
      if (take && rn_q.size() > 0) rn_q.delete(0);
      if (rn_q.size() > 0) begin
        {iRN_Last, i16RN_Data} = rn_q[0];
        iRN_Valid = 1'b1;
      end else begin
        iRN_Valid = 1'b0;
        iRN_Last  = 1'b0;
      end
    end
  end

  // Output monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge iClk);
      if (oTx_WriteEna) begin
        check("wr_while_full", {31'b0, iTx_Full}, 32'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_word", o32Tx_Data, e);
        end else begin
          check("unexpected_wr", {31'b0, oTx_WriteEna}, 32'd0);
        end
      end
      if (oGrant == 2'b01) check("rn_ready_while_gs", {31'b0, oRN_Ready}, 32'd0);
      if (oGrant == 2'b10) check("gs_ready_while_rn", {31'b0, oGS_Ready}, 32'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    iReset = 1'b0; iEnable = 1'b0; iTx_Full = 1'b0;
    cyc(3);
    check("rst_grant", 32'(oGrant), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_seq", 32'(o16PktSeq), 32'd0);
    check("rst_overlen", 32'(oOverLen), 32'd0);
    check("rst_wr", 32'(oTx_WriteEna), 32'd0);
    check("rst_ready", {30'b0, oGS_Ready, oRN_Ready}, 32'd0);
    iReset = 1'b1; iEnable = 1'b1;
    cyc(1);

    // Single GS packet
    gs_q.push_back({1'b0, 16'h1234});
    gs_q.push_back({1'b0, 16'h5678});
    gs_q.push_back({1'b1, 16'h9ABC});
    exp_q.push_back(32'hA5010000); exp_q.push_back(32'h01003412);
    exp_q.push_back(32'h01007856); exp_q.push_back(32'h0100BC9A);
    exp_q.push_back(32'h5A010003);
    drain("t1_drain");
    check("t1_seq", 32'(o16PktSeq), 32'd1);

    // Contention after a fresh reset: GS, RN, GS, RN
    iReset = 1'b0;
    cyc(2);
    iReset = 1'b1;
    gen(1'b0, 2, 16'h1000, 16'd0);
    gen(1'b1, 2, 16'h2000, 16'd1);
    gen(1'b0, 2, 16'h1100, 16'd2);
    gen(1'b1, 2, 16'h2100, 16'd3);
    drain("t2_drain");
    check("t2_seq", 32'(o16PktSeq), 32'd4);

    // FIFO full for 5 cycles in the middle of DATA
    gen(1'b0, 3, 16'h3000, 16'd4);
    t = 0;
    do begin
      @(negedge iClk);
      t++;
    end while (!(oTx_WriteEna && o32Tx_Data[31:24] == 8'h01) && t < 100);
    check("t3_reach_data", 32'(t < 100), 32'd1);
    @(posedge iClk); #1;
    iTx_Full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      check("t3_stall_ready", 32'(oGS_Ready), 32'd0);
      check("t3_stall_wr", 32'(oTx_WriteEna), 32'd0);
      @(posedge iClk); #1;
    end
    iTx_Full = 1'b0;
    drain("t3_drain");

    // RN truncation at MAX_PKT=4, remainder becomes a new packet
    for (int i = 0; i < 6; i++) rn_q.push_back({(i == 5), 16'h4000 + 16'(i)});
    exp_q.push_back(hdr(8'h02, 16'd5));
    for (int i = 0; i < 4; i++) exp_q.push_back(dat(8'h02, 16'h4000 + 16'(i)));
    exp_q.push_back(32'h5A820004);
    exp_q.push_back(hdr(8'h02, 16'd6));
    for (int i = 4; i < 6; i++) exp_q.push_back(dat(8'h02, 16'h4000 + 16'(i)));
    exp_q.push_back(32'h5A020002);
    drain("t4_drain");
    check("t4_overlen", 32'(oOverLen), 32'd1);

    // Enable dropped during a GS packet
    gen(1'b0, 3, 16'h5000, 16'd7);
    t = 0;
    while (!oBusy && t < 20) begin cyc(1); t++; end
    iEnable = 1'b0;
    rn_q.push_back({1'b0, 16'h6000});
    rn_q.push_back({1'b1, 16'h6101});
    drain("t5_gs_drain");
    cyc(20);
    check("t5_parked_grant", 32'(oGrant), 32'd0);
    check("t5_parked_busy", 32'(oBusy), 32'd0);
    exp_q.push_back(hdr(8'h02, 16'd8));
    exp_q.push_back(dat(8'h02, 16'h6000));
    exp_q.push_back(dat(8'h02, 16'h6101));
    exp_q.push_back(trl(8'h02, 1'b0, 16'd2));
    iEnable = 1'b1;
    drain("t5_rn_drain");

    // Reset in the middle of DATA
    gs_q.push_back({1'b0, 16'h7000});
    gs_q.push_back({1'b0, 16'h7101});
    gs_q.push_back({1'b1, 16'h7202});
    exp_q.push_back(hdr(8'h01, 16'd9));
    exp_q.push_back(dat(8'h01, 16'h7000));
    t = 0;
    do begin
      @(negedge iClk);
      t++;
    end while (!(oTx_WriteEna && o32Tx_Data[31:24] == 8'h01) && t < 100);
    @(posedge iClk); #1;
    iReset = 1'b0;
    gs_q.delete();
    @(negedge iClk);
    check("t6_rst_wr", 32'(oTx_WriteEna), 32'd0);
    cyc(1);
    check("t6_rst_busy", 32'(oBusy), 32'd0);
    check("t6_rst_seq", 32'(o16PktSeq), 32'd0);
    check("t6_rst_grant", 32'(oGrant), 32'd0);
    check("t6_no_trailer", 32'(exp_q.size()), 32'd0);
    iReset = 1'b1;
    gs_q.push_back({1'b1, 16'h1111});
    exp_q.push_back(32'hA5010000);
    exp_q.push_back(32'h01001111);
    exp_q.push_back(32'h5A010001);
    drain("t6_drain");
    check("t6_seq", 32'(o16PktSeq), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
